// File: rtl/fx_pt_sub_rnd_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fx_pt_defs
//   Shared fixed-point definitions for the fx_pt adder/subtractor family.
//   Provides the width helper used to size aligned operands, the round-half
//   constant used by the rounding stage, and the overflow counter type.
//   No ports (package).
// -----------------------------------------------------------------------------
package fx_pt_defs;

    localparam int unsigned FX_CNT_W = 8;

    typedef logic [FX_CNT_W-1:0] fx_cnt_t;

    // Larger of two widths.
    function automatic int fx_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Half of one output LSB when 'drop' low bits are discarded: 2^(drop-1).
    // Zero when nothing is dropped, so the rounding add becomes a no-op.
    function automatic logic [63:0] fx_rnd_half(input int unsigned drop);
        return (drop == 0) ? 64'd0 : (64'd1 << (drop - 1));
    endfunction

endpackage

// File: rtl/fx_pt_rnd_sat.sv
// -----------------------------------------------------------------------------
// fx_pt_rnd_sat
//   Round and saturate a two's-complement fixed-point value (IW bits total,
//   IFW fractional) to a DIW.DFW result. Rounding is half toward +infinity
//   when fractional bits are dropped, zero padding otherwise. SN selects the
//   output range: signed two's complement (1) or unsigned (0).
//   Ports:
//     i_val  in   IW       two's-complement input (sign-sufficient width)
//     o_val  out  DIW+DFW  rounded, clamped result
//     o_ovf  out  1        result was clamped
// -----------------------------------------------------------------------------
module fx_pt_rnd_sat
    import fx_pt_defs::*;
#(
    parameter int SN  = 1,
    parameter int IW  = 20,
    parameter int IFW = 9,
    parameter int DIW = 12,
    parameter int DFW = 7
) (
    input  logic [IW-1:0]      i_val,
    output logic [DIW+DFW-1:0] o_val,
    output logic               o_ovf
);

    localparam int OW   = DIW + DFW;
    localparam int DROP = (DFW < IFW)  ? (IFW - DFW) : 0;
    localparam int PAD  = (DFW >= IFW) ? (DFW - IFW) : 0;
    // One guard bit for the rounding add plus room for the left pad.
    localparam int XW   = IW + 2 + PAD;
    localparam int CW   = fx_max(XW, OW + 1);

    localparam logic signed [XW-1:0] RND = XW'(fx_rnd_half(DROP));

    logic signed [XW-1:0] w_x;
    logic signed [XW-1:0] w_sum;
    logic signed [XW-1:0] w_rnd;
    logic signed [CW-1:0] w_wide;
    logic signed [CW-1:0] w_max;
    logic signed [CW-1:0] w_min;

    assign w_x    = XW'(signed'(i_val));
    assign w_sum  = w_x + RND;
    // Arithmetic shift after the half-add floors, giving round half up.
    assign w_rnd  = (w_sum >>> DROP) <<< PAD;
    assign w_wide = CW'(w_rnd);

    if (SN != 0) begin : g_signed
        assign w_max = CW'(signed'({1'b0, {(OW-1){1'b1}}}));
        assign w_min = CW'(signed'({1'b1, {(OW-1){1'b0}}}));
    end else begin : g_unsigned
        assign w_max = CW'({OW{1'b1}});
        assign w_min = '0;
    end

    always_comb begin
        o_val = w_wide[OW-1:0];
        o_ovf = 1'b0;
        if (w_wide > w_max) begin
            o_val = w_max[OW-1:0];
            o_ovf = 1'b1;
        end else if (w_wide < w_min) begin
            o_val = w_min[OW-1:0];
            o_ovf = 1'b1;
        end
    end

endmodule

// File: rtl/fx_pt_sub_rnd_pipe.sv
// -----------------------------------------------------------------------------
// fx_pt_sub_rnd_pipe
//   Three-stage fixed-point subtractor diff = a - b with round-half-up and
//   saturation. S1 registers operands, S2 aligns and subtracts exactly,
//   S3 rounds/saturates and registers the result. The whole pipe advances
//   together whenever the output register is empty or being drained.
//   Ports:
//     clk        in   1        rising-edge clock
//     rst        in   1        asynchronous, active-low reset
//     in_a       in   AIW+AFW  minuend
//     in_b       in   BIW+BFW  subtrahend
//     in_valid   in   1        operand pair valid
//     in_ready   out  1        operand pair accepted this cycle
//     diff       out  DIW+DFW  rounded, saturated a - b
//     out_valid  out  1        diff valid
//     out_ready  in   1        sink accepts diff
//     ovf        out  1        presented diff was saturated
//     ovf_clr    in   1        synchronous clear of ovf_cnt
//     ovf_cnt    out  8        saturating count of accepted saturated results
// -----------------------------------------------------------------------------
module fx_pt_sub_rnd_pipe
    import fx_pt_defs::*;
#(
    parameter int SN  = 1,
    parameter int AIW = 9,
    parameter int AFW = 8,
    parameter int BIW = 10,
    parameter int BFW = 9,
    parameter int DIW = fx_max(AIW, BIW) + 2,
    parameter int DFW = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AIW+AFW-1:0]    in_a,
    input  logic [BIW+BFW-1:0]    in_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIW+DFW-1:0]    diff,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [FX_CNT_W-1:0]   ovf_cnt
);

    localparam int AW = AIW + AFW;
    localparam int BW = BIW + BFW;
    localparam int OW = DIW + DFW;
    localparam int F  = fx_max(AFW, BFW);
    // One extra integer bit makes the difference of two aligned operands exact.
    localparam int IW = fx_max(AIW, BIW) + 1;
    localparam int SW = IW + F;

    logic                w_adv;
    logic [SW-1:0]       w_a_ext;
    logic [SW-1:0]       w_b_ext;
    logic [OW-1:0]       w_rs;
    logic                w_rs_ovf;

    logic                r_v1;
    logic                r_v2;
    logic                r_v3;
    logic [AW-1:0]       r_a1;
    logic [BW-1:0]       r_b1;
    logic [SW-1:0]       r_d2;
    logic [OW-1:0]       r_diff;
    logic                r_ovf;
    logic [FX_CNT_W-1:0] r_cnt;

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign diff      = r_diff;
    assign ovf       = r_ovf;
    assign ovf_cnt   = r_cnt;

    if (SN != 0) begin : g_sext
        assign w_a_ext = SW'(signed'(r_a1)) << (F - AFW);
        assign w_b_ext = SW'(signed'(r_b1)) << (F - BFW);
    end else begin : g_zext
        assign w_a_ext = SW'(r_a1) << (F - AFW);
        assign w_b_ext = SW'(r_b1) << (F - BFW);
    end

    // The S2 difference is always two's complement, even for unsigned
    // operands, so negative results can be clamped to zero downstream.
    fx_pt_rnd_sat #(
        .SN  (SN),
        .IW  (SW),
        .IFW (F),
        .DIW (DIW),
        .DFW (DFW)
    ) u_rnd_sat (
        .i_val (r_d2),
        .o_val (w_rs),
        .o_ovf (w_rs_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_d2   <= '0;
            r_diff <= '0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_a1   <= in_a;
            r_b1   <= in_b;
            r_v2   <= r_v1;
            r_d2   <= w_a_ext - w_b_ext;
            r_v3   <= r_v2;
            r_diff <= w_rs;
            r_ovf  <= w_rs_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (ovf_clr) begin
            r_cnt <= '0;
        end else if (r_v3 && out_ready && r_ovf && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: doc/fx_pt_sub_rnd_pipe.md
FX_PT_SUB_RND_PIPE -- requirements
Module: fx_pt_sub_rnd_pipe

Interface
REQ-001 SHALL have parameter SN, default 1, meaning 1 = two's-complement signed operands and result, 0 = unsigned.
REQ-002 SHALL have parameter AIW, default 9, meaning integer bits of in_a.
REQ-003 SHALL have parameter AFW, default 8, meaning fractional bits of in_a.
REQ-004 SHALL have parameter BIW, default 10, meaning integer bits of in_b.
REQ-005 SHALL have parameter BFW, default 9, meaning fractional bits of in_b.
REQ-006 SHALL have parameter DIW, default max(AIW,BIW)+2, meaning integer bits of diff.
REQ-007 SHALL have parameter DFW, default 7, meaning fractional bits of diff.
REQ-008 SHALL have port clk, input, 1, the single clock, with all flops on its rising edge.
REQ-009 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-010 SHALL have port in_a, input, AIW+AFW, the minuend.
REQ-011 SHALL have port in_b, input, BIW+BFW, the subtrahend.
REQ-012 SHALL have port in_valid, input, 1, meaning the operand pair is valid.
REQ-013 SHALL have port in_ready, output, 1, meaning the block accepts an operand pair this cycle.
REQ-014 SHALL have port diff, output, DIW+DFW, the rounded and saturated a-b.
REQ-015 SHALL have port out_valid, output, 1, meaning diff is valid.
REQ-016 SHALL have port out_ready, input, 1, meaning the sink accepts diff.
REQ-017 SHALL have port ovf, output, 1, meaning the presented diff was saturated.
REQ-018 SHALL have port ovf_clr, input, 1, a synchronous clear of ovf_cnt.
REQ-019 SHALL have port ovf_cnt, output, 8, a saturating count of accepted saturated results.

Function
REQ-020 The block SHALL be a 3-stage pipeline: S1 operand register; S2 align and subtract; S3 round, saturate and output register.
REQ-021 Latency SHALL be 3 cycles from in_valid&&in_ready to out_valid with no stall.
REQ-022 Throughput SHALL be one result per cycle.
REQ-023 Advance: adv = !out_valid || out_ready; in_ready = adv, combinational; every stage's data and valid bit SHALL hold when adv=0.
REQ-024 Bubbles SHALL propagate as valid=0, and data in invalid stages is don't-care.
REQ-025 Transfer SHALL occur only when valid&&ready at a rising edge; diff and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Alignment: both operands SHALL be extended to F=max(AFW,BFW) fractional bits by zero-padding LSBs, sign-extended (SN=1) or zero-extended (SN=0) to max(AIW,BIW)+1 integer bits.
REQ-027 Subtraction in S2 SHALL be exact, with no overflow possible at that width.
REQ-028 Rounding, if DFW<F: add 2^(F-DFW-1) and then drop the F-DFW LSBs (round half toward +infinity).
REQ-029 Rounding, if DFW>=F: zero-pad, no rounding.
REQ-030 The rounding add SHALL be one bit wider so it cannot wrap.
REQ-031 Saturation, SN=1: clamp to [-2^(DIW+DFW-1), 2^(DIW+DFW-1)-1] and set ovf=1 when clamped.
REQ-032 Saturation, SN=0: negative results SHALL clamp to 0; results above 2^(DIW+DFW)-1 SHALL clamp to all-ones; ovf=1 in either case.
REQ-033 ovf_cnt SHALL increment by 1 on each out_valid&&out_ready&&ovf and hold at 255.
REQ-034 ovf_clr=1 SHALL force ovf_cnt to 0 next cycle; clear wins over a simultaneous increment.

Reset
REQ-035 rst low SHALL asynchronously force all stage valid bits, diff, ovf and ovf_cnt to 0, and in_ready SHALL follow adv (1 during reset).
REQ-036 Reset asserted mid-stream SHALL discard all in-flight results, with no out_valid produced for them after release.
REQ-037 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-038 A shared header fx_pt_defs SHALL hold the max() width function and the round-half constant helper used by the existing fixed-point adders and this block.
REQ-039 S3 SHALL be a sub-module fx_pt_rnd_sat (parameters SN, input width/frac, DIW, DFW; outputs value and ovf), reusable by the adder family.

Verification (defaults unless stated)
REQ-040 in_a=0x00180 (1.5), in_b=0x00080 (0.25), out_ready=1 -> diff=160 (1.25) exactly 3 cycles later, ovf=0.
REQ-041 in_a=1 (2^-8), in_b=0 -> diff=1 (2^-7, half rounded up); in_a=0, in_b=1 (-2^-9) -> diff=0.
REQ-042 DIW=4, in_a=100.0, in_b=-50.0 -> diff=0x3FF, ovf=1, ovf_cnt=1; repeat 300 times -> ovf_cnt=255.
REQ-043 SN=0, in_a=1.0, in_b=2.0 -> diff=0, ovf=1.
REQ-044 Back-to-back 10 pairs with out_ready low on cycles 5-7 -> in_ready low on the same cycles, diff held stable, all 10 results in order, none lost or duplicated.
REQ-045 rst pulsed low with 3 results in flight -> out_valid=0 immediately, no stale result after release; ovf_clr coincident with an overflow transfer -> ovf_cnt=0.
